// File: rtl/pattern_loader.sv
// ============================================================================
// Module      : pattern_loader
// Description : Assembles, edits and locks a NUM_SLOTS-slot shape pattern for
//               the grader. Optional macro UNIQUE_SHAPES_EN rejects duplicates.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_loader #(
    parameter int NUM_SLOTS = 4,
    parameter int SHAPE_W   = 3
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic [SHAPE_W-1:0]           shape_in,
    input  logic                         shape_valid,
    input  logic                         undo,
    input  logic                         commit,
    input  logic                         clear,
    output logic [NUM_SLOTS*SHAPE_W-1:0] masterPattern,
    output logic                         pattern_valid,
    output logic [2:0]                   slot_count,
    output logic                         err
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    localparam logic [2:0] FULL_COUNT = 3'(NUM_SLOTS);

    state_t                         state, state_next;
    logic [NUM_SLOTS*SHAPE_W-1:0]   pattern, pattern_next;
    logic [2:0]                     count, count_next;
    logic                           valid_q;
    logic                           err_q, err_next;
    logic                           code_ok;
    logic                           duplicate;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= EMPTY;
            pattern <= '0;
            count   <= 3'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_next;
            pattern <= pattern_next;
            count   <= count_next;
            valid_q <= (state_next == LOCKED);
            err_q   <= err_next;
        end
    end

    // Codes 000 and 111 are not shapes.
    assign code_ok = (shape_in != '0) && (shape_in != '1);

    always_comb begin
        duplicate = 1'b0;
`ifdef UNIQUE_SHAPES_EN
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if ((3'(k) < count) &&
                (pattern[(NUM_SLOTS-1-k)*SHAPE_W +: SHAPE_W] == shape_in)) begin
                duplicate = 1'b1;
            end
        end
`endif
    end

    // Priority: clear > undo > commit > shape_valid; lower strobes are dropped.
    always_comb begin
        state_next   = state;
        pattern_next = pattern;
        count_next   = count;
        err_next     = 1'b0;

        if (clear) begin
            state_next   = EMPTY;
            pattern_next = '0;
            count_next   = 3'd0;
        end else if (undo) begin
            if (state == FILLING || state == FULL) begin
                for (int k = 0; k < NUM_SLOTS; k++) begin
                    if (3'(k) == count - 3'd1) begin
                        pattern_next[(NUM_SLOTS-1-k)*SHAPE_W +: SHAPE_W] = '0;
                    end
                end
                count_next = count - 3'd1;
                state_next = (count == 3'd1) ? EMPTY : FILLING;
            end else begin
                err_next = 1'b1;
            end
        end else if (commit) begin
            if (state == FULL) begin
                state_next = LOCKED;
            end else begin
                err_next = 1'b1;
            end
        end else if (shape_valid) begin
            if ((state == EMPTY || state == FILLING) && code_ok && !duplicate) begin
                for (int k = 0; k < NUM_SLOTS; k++) begin
                    if (3'(k) == count) begin
                        pattern_next[(NUM_SLOTS-1-k)*SHAPE_W +: SHAPE_W] = shape_in;
                    end
                end
                count_next = count + 3'd1;
                state_next = (count + 3'd1 == FULL_COUNT) ? FULL : FILLING;
            end else begin
                err_next = 1'b1;
            end
        end
    end

    assign masterPattern = pattern;
    assign pattern_valid = valid_q;
    assign slot_count    = count;
    assign err           = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pattern_loader.sv
// ============================================================================
// Module      : tb_pattern_loader
// Description : Scoreboard bench for pattern_loader with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pattern_loader;

    logic        CLOCK_50;
    logic        reset;
    logic [2:0]  shape_in;
    logic        shape_valid;
    logic        undo;
    logic        commit;
    logic        clear;
    logic [11:0] masterPattern;
    logic        pattern_valid;
    logic [2:0]  slot_count;
    logic        err;

    typedef struct {
        string       name;
        logic [11:0] pat;
        logic [2:0]  cnt;
        logic        vld;
        logic        er;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 0;

    pattern_loader #(.NUM_SLOTS(4), .SHAPE_W(3)) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .shape_in      (shape_in),
        .shape_valid   (shape_valid),
        .undo          (undo),
        .commit        (commit),
        .clear         (clear),
        .masterPattern (masterPattern),
        .pattern_valid (pattern_valid),
        .slot_count    (slot_count),
        .err           (err)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Drive one cycle of stimulus and queue the outputs expected after the edge.
    task automatic cyc(input string nm, input logic rs, input logic sv,
                       input logic [2:0] sh, input logic un, input logic cm,
                       input logic cl, input logic [11:0] ep,
                       input logic [2:0] ec, input logic ev, input logic ee);
        exp_t e;
        @(negedge CLOCK_50);
        reset       = rs;
        shape_valid = sv;
        shape_in    = sh;
        undo        = un;
        commit      = cm;
        clear       = cl;
        e.name = nm; e.pat = ep; e.cnt = ec; e.vld = ev; e.er = ee;
        exp_q.push_back(e);
    endtask

    always @(posedge CLOCK_50) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (masterPattern !== e.pat || slot_count !== e.cnt ||
                pattern_valid !== e.vld || err !== e.er) begin
                errors++;
                $display("FAIL %s: got pat=%b cnt=%0d vld=%b err=%b, expected pat=%b cnt=%0d vld=%b err=%b",
                         e.name, masterPattern, slot_count, pattern_valid, err,
                         e.pat, e.cnt, e.vld, e.er);
            end
        end
    end

    initial begin
        reset = 1'b1; shape_valid = 1'b0; shape_in = 3'd0;
        undo = 1'b0; commit = 1'b0; clear = 1'b0;

        cyc("reset0", 1,0,3'b000,0,0,0, 12'b000_000_000_000, 3'd0, 0, 0);
        cyc("reset1", 1,1,3'b101,0,0,0, 12'b000_000_000_000, 3'd0, 0, 0);

        // Fill I,Z,D,T and commit
        cyc("fill1",  0,1,3'b101,0,0,0, 12'b101_000_000_000, 3'd1, 0, 0);
        cyc("fill2",  0,1,3'b110,0,0,0, 12'b101_110_000_000, 3'd2, 0, 0);
        cyc("fill3",  0,1,3'b100,0,0,0, 12'b101_110_100_000, 3'd3, 0, 0);
        cyc("fill4",  0,1,3'b001,0,0,0, 12'b101_110_100_001, 3'd4, 0, 0);
        cyc("commit", 0,0,3'b000,0,1,0, 12'b101_110_100_001, 3'd4, 1, 0);
        cyc("lockhold",0,0,3'b000,0,0,0,12'b101_110_100_001, 3'd4, 1, 0);
        cyc("clear1", 0,0,3'b000,0,0,1, 12'b000_000_000_000, 3'd0, 0, 0);

        // Undo sequence
        cyc("u_a",    0,1,3'b001,0,0,0, 12'b001_000_000_000, 3'd1, 0, 0);
        cyc("u_b",    0,1,3'b010,0,0,0, 12'b001_010_000_000, 3'd2, 0, 0);
        cyc("undo1",  0,0,3'b000,1,0,0, 12'b001_000_000_000, 3'd1, 0, 0);
        cyc("u_c",    0,1,3'b011,0,0,0, 12'b001_011_000_000, 3'd2, 0, 0);
        cyc("undo2",  0,0,3'b000,1,0,0, 12'b001_000_000_000, 3'd1, 0, 0);
        cyc("undo3",  0,0,3'b000,1,0,0, 12'b000_000_000_000, 3'd0, 0, 0);
        cyc("undo_empty",0,0,3'b000,1,0,0,12'b000_000_000_000,3'd0, 0, 1);
        cyc("err_drop",0,0,3'b000,0,0,0,12'b000_000_000_000, 3'd0, 0, 0);

        // Invalid codes and misplaced strobes
        cyc("code000",0,1,3'b000,0,0,0, 12'b000_000_000_000, 3'd0, 0, 1);
        cyc("code111",0,1,3'b111,0,0,0, 12'b000_000_000_000, 3'd0, 0, 1);
        cyc("e_a",    0,1,3'b010,0,0,0, 12'b010_000_000_000, 3'd1, 0, 0);
        cyc("commit_fill",0,0,3'b000,0,1,0,12'b010_000_000_000,3'd1,0, 1);
        cyc("e_b",    0,1,3'b011,0,0,0, 12'b010_011_000_000, 3'd2, 0, 0);
        cyc("e_c",    0,1,3'b100,0,0,0, 12'b010_011_100_000, 3'd3, 0, 0);
        cyc("e_d",    0,1,3'b101,0,0,0, 12'b010_011_100_101, 3'd4, 0, 0);
        cyc("sv_full",0,1,3'b001,0,0,0, 12'b010_011_100_101, 3'd4, 0, 1);
        cyc("idle1",  0,0,3'b000,0,0,0, 12'b010_011_100_101, 3'd4, 0, 0);

        // LOCKED rejects everything but clear
        cyc("lock",   0,0,3'b000,0,1,0, 12'b010_011_100_101, 3'd4, 1, 0);
        cyc("sv_lock",0,1,3'b110,0,0,0, 12'b010_011_100_101, 3'd4, 1, 1);
        cyc("undo_lock",0,0,3'b000,1,0,0,12'b010_011_100_101,3'd4, 1, 1);
        cyc("cm_lock",0,0,3'b000,0,1,0, 12'b010_011_100_101, 3'd4, 1, 1);
        cyc("idle2",  0,0,3'b000,0,0,0, 12'b010_011_100_101, 3'd4, 1, 0);
        cyc("clear2", 0,0,3'b000,0,0,1, 12'b000_000_000_000, 3'd0, 0, 0);

        // Priority between simultaneous strobes
        cyc("p_a",    0,1,3'b011,0,0,0, 12'b011_000_000_000, 3'd1, 0, 0);
        cyc("p_b",    0,1,3'b110,0,0,0, 12'b011_110_000_000, 3'd2, 0, 0);
        cyc("undo_sv",0,1,3'b001,1,0,0, 12'b011_000_000_000, 3'd1, 0, 0);
        cyc("p_c",    0,1,3'b110,0,0,0, 12'b011_110_000_000, 3'd2, 0, 0);
        cyc("p_d",    0,1,3'b001,0,0,0, 12'b011_110_001_000, 3'd3, 0, 0);
        cyc("p_e",    0,1,3'b100,0,0,0, 12'b011_110_001_100, 3'd4, 0, 0);
        cyc("clr_cm", 0,0,3'b000,0,1,1, 12'b000_000_000_000, 3'd0, 0, 0);
        cyc("idle3",  0,0,3'b000,0,0,0, 12'b000_000_000_000, 3'd0, 0, 0);

        // Reset mid-fill
        cyc("r_a",    0,1,3'b101,0,0,0, 12'b101_000_000_000, 3'd1, 0, 0);
        cyc("r_b",    0,1,3'b110,0,0,0, 12'b101_110_000_000, 3'd2, 0, 0);
        cyc("r_c",    0,1,3'b100,0,0,0, 12'b101_110_100_000, 3'd3, 0, 0);
        cyc("reset_mid",1,1,3'b001,0,0,0,12'b000_000_000_000,3'd0, 0, 0);
        cyc("idle4",  0,0,3'b000,0,0,0, 12'b000_000_000_000, 3'd0, 0, 0);

        // Duplicate handling
        cyc("d_a",    0,1,3'b110,0,0,0, 12'b110_000_000_000, 3'd1, 0, 0);
        cyc("d_b",    0,1,3'b010,0,0,0, 12'b110_010_000_000, 3'd2, 0, 0);
`ifdef UNIQUE_SHAPES_EN
        cyc("dup_rej",0,1,3'b110,0,0,0, 12'b110_010_000_000, 3'd2, 0, 1);
        cyc("d_undo", 0,0,3'b000,1,0,0, 12'b110_000_000_000, 3'd1, 0, 0);
        cyc("d_re",   0,1,3'b010,0,0,0, 12'b110_010_000_000, 3'd2, 0, 0);
`else
        cyc("dup_c",  0,1,3'b110,0,0,0, 12'b110_010_110_000, 3'd3, 0, 0);
        cyc("dup_d",  0,1,3'b110,0,0,0, 12'b110_010_110_110, 3'd4, 0, 0);
        cyc("dup_lock",0,0,3'b000,0,1,0,12'b110_010_110_110, 3'd4, 1, 0);
`endif
        cyc("final",  0,0,3'b000,0,0,1, 12'b000_000_000_000, 3'd0, 0, 0);

        repeat (3) @(posedge CLOCK_50);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        stim_done = 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        if (!stim_done) begin
            $display("FAIL timeout: stimulus not complete, expected completion");
            $fatal(1, "timeout");
        end
    end

endmodule

`default_nettype wire
